// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Saturating multiply-accumulate back end. Sums COUNT unsigned
//               products taken over a valid/ready handshake and presents the
//               total, with a sticky overflow flag, on a second handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
  parameter int PROD_W = 4,
  parameter int ACC_W  = 8,
  parameter int COUNT  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [PROD_W-1:0] Product,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              Clear,
  output logic [ACC_W-1:0]  Sum,
  output logic              Overflow,
  output logic              Out_Valid,
  input  logic              Out_Ready
);

  // ACC collects products, DONE holds a finished result for the consumer.
  typedef enum logic [0:0] {
    c_st_acc  = 1'b0,
    c_st_done = 1'b1
  } state_t;

  localparam logic [7:0]       c_last    = 8'(COUNT - 1);
  localparam logic [ACC_W-1:0] c_acc_max = {ACC_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf;

  logic [ACC_W:0]   w_sum_ext;
  logic             w_sat;
  logic             w_accept;
  logic             w_release;
  logic             w_last;

  // Handshake outputs come only from registered state (plus reset gating),
  // so there is no combinational path from In_Valid or Out_Ready.
  assign In_Ready  = (r_state == c_st_acc) && !Rst;
  assign Out_Valid = (r_state == c_st_done);
  assign Sum       = r_acc;
  assign Overflow  = r_ovf;

  assign w_accept  = In_Valid && In_Ready;
  assign w_release = Out_Valid && Out_Ready;
  assign w_last    = (r_cnt == c_last);

  // One extra bit of headroom exposes the carry that signals saturation.
  assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, Product};
  assign w_sat     = w_sum_ext[ACC_W];

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= c_st_acc;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: Clear wins over both accept and release.
  always_comb begin
    w_state_nxt = r_state;
    if (Clear) begin
      w_state_nxt = c_st_acc;
    end else begin
      case (r_state)
        c_st_acc:  if (w_accept && w_last) w_state_nxt = c_st_done;
        c_st_done: if (w_release)          w_state_nxt = c_st_acc;
        default:   w_state_nxt = c_st_acc;
      endcase
    end
  end

  // Accumulator, product counter and sticky overflow.
  always_ff @(posedge Clk) begin
    if (Rst || Clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_sat) begin
        r_acc <= c_acc_max;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum_ext[ACC_W-1:0];
      end
      r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
    end else if (w_release) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage directly downstream of the 2x2 unsigned Multiplier in the fixed-point ALU. It consumes the multiplier's `Out` product over a valid/ready handshake and sums a fixed number of products into a saturating accumulator. It then presents the result, with a sticky overflow flag, on a second valid/ready handshake. This makes the block the dot-product/MAC back end of the ALU.

## Interface
- `PROD_W`, default 4: product width. Matches the Multiplier `Out` width.
- `ACC_W`, default 8: accumulator and result width. Legal range: ACC_W >= PROD_W.
- `COUNT`, default 4: products summed per result. Legal range: 1..255.

Ports:
- `Clk` in 1: single clock; all state updates on rising edge.
- `Rst` in 1: reset, synchronous, active-high.
- `Product` in PROD_W: unsigned product from the Multiplier.
- `In_Valid` in 1: `Product` is valid.
- `In_Ready` out 1: block accepts `Product` this cycle.
- `Clear` in 1: abort the current accumulation or result.
- `Sum` out ACC_W: accumulator value. Meaningful only while `Out_Valid` = 1.
- `Overflow` out 1: at least one saturation occurred in the current result.
- `Out_Valid` out 1: `Sum` and `Overflow` hold a completed result.
- `Out_Ready` in 1: consumer takes the result.

## Operation
- States:
  - ACC: accepting products.
  - DONE: holding a result.
- Internal counter `cnt` is 8 bits, range 0..COUNT-1.
- Reset (Rst = 1 at an edge):
  - state = ACC; acc = 0; cnt = 0; Overflow = 0; Out_Valid = 0.
  - `In_Ready` is forced 0 while Rst is high.
- `In_Ready` = (state == ACC) and not Rst. `Out_Valid` = (state == DONE). Both are decoded from registered state; there is no combinational path from In_Valid or Out_Ready.
- Accept: In_Valid and In_Ready at an edge.
  - Compute t = acc + zero-extended Product in ACC_W+1 bits.
  - If t > 2^ACC_W − 1: acc = 2^ACC_W − 1 and Overflow = 1.
  - Otherwise acc = t[ACC_W−1:0].
  - Overflow is sticky until the result is released.
- On the accept where cnt == COUNT−1: state becomes DONE and cnt = 0. Otherwise cnt increments.
- COUNT = 1: every accept moves the block to DONE.
- In DONE:
  - Sum and Overflow are held stable.
  - In_Ready = 0 (backpressure to the Multiplier side).
- Release: Out_Valid and Out_Ready at an edge.
  - state = ACC; acc = 0; Overflow = 0.
- Clear, at an edge in any state:
  - acc = 0; cnt = 0; Overflow = 0; state = ACC.
  - Clear overrides a simultaneous accept: the product is dropped.
  - Clear overrides a simultaneous release: the consumer must treat that handshake as void.
- Priority: Rst > Clear > release/accept. Accept and release never coincide, because In_Ready is 0 in DONE.
- Arithmetic is unsigned throughout. Product is zero-extended and no sign handling is performed.

## Timing
- Accept latency: acc reflects a product the cycle after its accept edge.
- Result latency: Out_Valid rises the cycle after the COUNT-th accept.
- Best-case throughput: COUNT products per COUNT+1 cycles. This needs In_Valid held high and Out_Ready high, giving one release cycle per result.
- After a release edge, In_Ready = 1 in the next cycle.
- Bubbles on In_Valid stall cnt and acc. There is no timeout.
- Out_Ready held low keeps the block in DONE indefinitely, with outputs frozen.
- Reset mid-operation: all outputs take reset values the cycle after the Rst edge. Any partial sum is lost.

## Test plan
- Defaults, In_Valid held high, products 9, 9, 9, 9 with Out_Ready = 1:
  - Out_Valid rises 1 cycle after the 4th accept.
  - Sum = 36, Overflow = 0.
  - In_Ready returns 1 the cycle after release.
- ACC_W = 5, products 9, 9, 9, 9:
  - Sum = 31 (saturated), Overflow = 1.
  - The next result from products 1, 1, 1, 1 gives Sum = 4, Overflow = 0.
- Backpressure: products 2, 3, 4, 6 (Sum = 15), then Out_Ready = 0 for 5 cycles:
  - Out_Valid = 1, Sum = 15, In_Ready = 0 for all 5 cycles.
  - In_Valid = 1 with Product = 9 during that window is ignored.
  - Release occurs on the first Out_Ready = 1 cycle.
- Clear mid-accumulation: accept 3 and 6, then assert Clear together with In_Valid/Product = 9:
  - The product 9 is dropped.
  - Subsequent products 1, 1, 1, 1 give Sum = 4.
- Clear during DONE with Out_Ready = 1 in the same cycle:
  - Next cycle Out_Valid = 0, Sum = 0, In_Ready = 1.
- Reset: Rst = 1 while in DONE (Sum = 20):
  - Next cycle Out_Valid = 0, Sum = 0, Overflow = 0.
  - In_Ready = 0 while Rst is high, and 1 after Rst drops.
- In_Valid with random bubbles (products 1, 2, 3, 4 over 10 cycles):
  - Sum = 10 after exactly 4 accepts.
